// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with synchronized, glitch-filtered
// inputs, index-driven load pulse and sticky illegal-transition tracking.
module quad_decoder #(
  parameter int          FILT_LEN     = 4,
  parameter logic [15:0] IDX_LOAD_VAL = 16'h0000
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst_n,
  input  logic        i_enc_a,
  input  logic        i_enc_b,
  input  logic        i_enc_idx,
  input  logic        i_en,
  input  logic        i_idx_en,
  input  logic        i_err_clr,
  output logic        o_cnt_en,
  output logic        o_dir,
  output logic        o_ld,
  output logic [15:0] o_ld_data,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);

  // Five bits cover both the filter count (up to 15) and the INIT length (up to 17).
  localparam int            CW        = 5;
  localparam logic [CW-1:0] FILT_MAX  = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(FILT_LEN + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      init_cnt;
  logic [CW-1:0]      init_cnt_nxt;

  // Input vectors are packed as {idx, a, b}.
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         filt;
  logic [2:0][CW-1:0] filt_cnt;

  logic [1:0]         ref_ab;
  logic               idx_prev;

  logic [1:0]         ab_chg;
  logic               is_run;
  logic               step;
  logic               illegal;
  logic               step_up;
  logic               idx_rise;
  logic               cnt_en_nxt;
  logic               dir_nxt;
  logic               ld_nxt;
  logic               err_nxt;
  logic [7:0]         err_cnt_base;
  logic [7:0]         err_cnt_nxt;

  assign o_ld_data = IDX_LOAD_VAL;

  // Two-flop synchronizer for the asynchronous encoder pins.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {i_enc_idx, i_enc_a, i_enc_b};
      sync2 <= sync1;
    end
  end

  // Per-input glitch filter; INIT loads the synchronized values directly.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      filt     <= '0;
      filt_cnt <= '0;
    end else if (state == INIT) begin
      filt     <= sync2;
      filt_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_MAX) begin
          filt[i]     <= sync2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Reference copy of the filtered inputs, tracked in every state and enable setting.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      ref_ab   <= '0;
      idx_prev <= 1'b0;
    end else begin
      ref_ab   <= filt[1:0];
      idx_prev <= filt[2];
    end
  end

  // State and INIT-length counter registers.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Next-state logic and decode of the next registered output values.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (state == INIT) begin
      init_cnt_nxt = init_cnt + 1'b1;
      if (init_cnt == INIT_LAST) begin
        state_nxt = RUN;
      end
    end

    is_run   = (state == RUN);
    ab_chg   = filt[1:0] ^ ref_ab;
    step     = is_run && (ab_chg == 2'b01 || ab_chg == 2'b10);
    illegal  = is_run && (ab_chg == 2'b11);
    // Up sequence in {A,B}: 00 -> 10 -> 11 -> 01 -> 00.
    step_up  = ab_chg[1] ? (filt[1] ^ ref_ab[0]) : ~(filt[0] ^ ref_ab[1]);
    idx_rise = is_run && filt[2] && !idx_prev;

    ld_nxt     = idx_rise && i_en && i_idx_en;
    cnt_en_nxt = step && i_en && !ld_nxt;
    dir_nxt    = cnt_en_nxt ? step_up : o_dir;

    err_cnt_base = i_err_clr ? 8'h00 : o_err_cnt;
    err_nxt      = i_err_clr ? 1'b0 : o_err;
    err_cnt_nxt  = err_cnt_base;
    if (illegal) begin
      err_nxt     = 1'b1;
      err_cnt_nxt = (err_cnt_base == 8'hFF) ? 8'hFF : err_cnt_base + 8'd1;
    end
  end

  // Registered outputs.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      o_cnt_en  <= 1'b0;
      o_dir     <= 1'b1;
      o_ld      <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= 8'h00;
    end else begin
      o_cnt_en  <= cnt_en_nxt;
      o_dir     <= dir_nxt;
      o_ld      <= ld_nxt;
      o_err     <= err_nxt;
      o_err_cnt <= err_cnt_nxt;
    end
  end

endmodule
